bcd_seg_scan: RTL and testbench
===============================

Name: bcd_seg_scan

Overview:
- Display end of the digit-counter path: takes DIGITS packed BCD digits from the counters and drives a time-multiplexed common-anode seven-segment display.
- One digit is lit per scan slot.
- Includes a per-frame input snapshot (no tearing), a one-cycle anti-ghost gap on every digit change, leading-zero blanking and a dash for invalid codes.

Parameters:
- DIGITS, 4, number of display digits (1..8).
- SCAN_DIV, 50000, clk cycles per scan slot; must be >= 4.
- SEG_ACTIVE_LOW, 1, 1 = seg/dp outputs inverted (low lights segment).
- AN_ACTIVE_LOW, 1, 1 = an outputs inverted (low selects digit).
- BLANK_LZ, 1, 1 = leading-zero blanking enabled.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  display enable; low freezes scan and darkens display.
- bcd  input  4*DIGITS  digit i at bits [4i+3:4i]; digit 0 is least significant.
- dp_in  input  DIGITS  decimal point request per digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, bit 0 = a.
- dp  output  1  decimal point of the lit digit.
- an  output  DIGITS  digit select, one-hot or all inactive.
- frame_start  output  1  one-cycle pulse when the snapshot loads.

Behaviour:
- Reset (rst high at a clk edge):
  - Prescaler and slot index idx are set to 0; snapshot registers are set to 0.
  - an, seg and dp go inactive (all off, polarity per parameters); frame_start = 0.
  - load_pending is set to 1.
  - rst mid-frame aborts the frame immediately, with no partial completion.
- Prescaler:
  - Counts 0..SCAN_DIV-1 while en = 1.
  - tick is asserted in the cycle where the count = SCAN_DIV-1; the count then wraps to 0.
- Slot advance:
  - On tick, idx <= idx+1, wrapping from DIGITS-1 to 0.
- Snapshot:
  - bcd and dp_in are copied into the snapshot on a tick with idx = DIGITS-1, or on the first en = 1 cycle while load_pending = 1 (this clears load_pending).
  - frame_start pulses in the same cycle the copy is registered.
  - Input changes at any other time have no visible effect until the next load.
- Output timing, with T = the tick cycle:
  - Edge after T: an goes all inactive (gap cycle); seg and dp go inactive.
  - Following edge: an = one-hot(idx); seg and dp are decoded from snapshot digit idx.
  - The new digit is therefore visible 2 cycles after tick and held for SCAN_DIV-1 cycles.
  - After reset, the first digit appears 2 cycles after the first en = 1 cycle.
- Decode, active-high form (inverted when SEG_ACTIVE_LOW = 1):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Codes 10..15 display 0x40 (dash).
- Leading-zero blanking (BLANK_LZ = 1):
  - Scanning from digit DIGITS-1 downward, each digit with code 0 is blanked until the first non-zero code (valid or invalid) is found.
  - Digit 0 is never blanked.
  - A blanked digit's slot still elapses, but an stays all inactive and seg/dp are off.
  - dp_in on a blanked digit is ignored.
- en = 0:
  - On the next edge, an/seg/dp go inactive.
  - Prescaler, idx and snapshot hold.
  - When en returns to 1, the next edge re-drives the current idx (gap cycle first, then the digit) and counting resumes from the held prescaler value.
- Simultaneous rst and en: rst wins.
- Simultaneous snapshot-load tick and input change: the value present at that edge is captured.

Test Plan:
All scenarios use DIGITS=4, SCAN_DIV=4, SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0, BLANK_LZ=1 unless noted.
1. rst 2 cycles, then en=1, bcd=0x0123 -> frame_start pulses. Slots cycle 0..3 at 4 cycles each, with 1 gap cycle per slot:
   - slot 0: an=0001, seg=0x4F
   - slot 1: an=0010, seg=0x5B
   - slot 2: an=0100, seg=0x06
   - slot 3: an=0000 (blanked)
2. bcd=0x0000, dp_in=4'b1001 -> slot 0: an=0001, seg=0x3F, dp=1. Slots 1-3: an=0000, dp=0.
3. bcd=0x0A05 -> slot 0: seg=0x6D; slot 1: seg=0x3F (not blanked); slot 2: seg=0x40 dash; slot 3: blanked.
4. Frame showing 0x1234; change bcd to 0x5678 during slot 1 -> slots 1-3 still show 2,3,4. frame_start pulses at the slot-3 tick; the next slot 0 shows seg=0x7F (8).
5. Deassert en for 10 cycles mid-slot 2 -> an=0000 and seg=0x00 on the next edge, prescaler holds. On re-enable: 1 gap cycle, then slot 2 resumes for its remaining count.
6. Assert rst during slot 2 with bcd=0x0009 -> an=0000 on the next edge. After release: slot 0 shows seg=0x6F at cycle 2; slots 1-3 blanked. Repeat with SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1 -> seg=0x10, an=1110.

Source files
------------

// File: rtl/bcd_seg_scan.sv
// Purpose : time-multiplexed common-anode 7-segment driver for DIGITS packed BCD digits,
//           with per-frame snapshot, leading-zero blanking and a dash for codes 10..15.
// Latency : a digit becomes visible 2 cycles after its scan tick (one dark gap cycle first);
//           the first digit after reset appears 2 cycles after the first en=1 cycle.
// Backpressure: none; en=0 freezes the scan state and darkens the display.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   en           : display enable
//   bcd          : DIGITS x 4-bit BCD, digit 0 in bits [3:0]
//   dp_in        : decimal-point request per digit
//   seg, dp, an  : segment {g..a}, decimal point, digit select (polarity per parameters)
//   frame_start  : one-cycle pulse in the cycle a new snapshot is held

module bcd_seg_scan #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

  // Inactive output levels in the external polarity.
  localparam logic [6:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Active-high segment patterns; anything above 9 shows a dash.
  function automatic logic [6:0] decode_bcd(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  // State registers
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_bcd_q, snap_bcd_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                load_pending_q, load_pending_d;
  logic                en_prev_q, en_prev_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_start_q, frame_start_d;

  // Combinational helpers
  logic                tick;
  logic                load;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic                cur_blank;
  logic [DIGITS-1:0]   an_raw;
  logic [6:0]          seg_raw;

  assign tick = en && (cnt_q == CNT_LAST);

  // A snapshot is taken at the end of the last slot of a frame, or as soon
  // as the display is first enabled after reset.
  assign load = en && (load_pending_q || (tick && (idx_q == IDX_LAST)));

  // Leading-zero mask: walk from the most significant digit down and blank
  // zeros until any non-zero code (including invalid ones) is seen.
  // Digit 0 is never blanked so a value of zero still shows "0".
  always_comb begin
    logic seen_nz;
    blank   = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (snap_bcd_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      blank[i] = !seen_nz;
    end
  end

  assign cur_code  = snap_bcd_q[{idx_q, 2'b00} +: 4];
  assign cur_dp    = snap_dp_q[idx_q];
  assign cur_blank = (BLANK_LZ != 0) && blank[idx_q];
  assign seg_raw   = decode_bcd(cur_code);

  always_comb begin
    an_raw        = '0;
    an_raw[idx_q] = 1'b1;
  end

  // Next-state logic
  always_comb begin
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    snap_bcd_d     = snap_bcd_q;
    snap_dp_d      = snap_dp_q;
    load_pending_d = load_pending_q;
    en_prev_d      = en;
    seg_d          = SEG_OFF;
    dp_d           = DP_OFF;
    an_d           = AN_OFF;
    frame_start_d  = load;

    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      // Enabling once is enough to consume the post-reset load request.
      load_pending_d = 1'b0;
    end

    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (load) begin
      snap_bcd_d = bcd;
      snap_dp_d  = dp_in;
    end

    // The gap cycle (all anodes off) follows every tick and every return of
    // en, so the previous digit's segments never bleed into the next anode.
    if (en && !tick && en_prev_q && !cur_blank) begin
      an_d  = (AN_ACTIVE_LOW  != 0) ? ~an_raw  : an_raw;
      seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
      dp_d  = (SEG_ACTIVE_LOW != 0) ? ~cur_dp  : cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      snap_bcd_q     <= '0;
      snap_dp_q      <= '0;
      load_pending_q <= 1'b1;
      en_prev_q      <= 1'b0;
      seg_q          <= SEG_OFF;
      dp_q           <= DP_OFF;
      an_q           <= AN_OFF;
      frame_start_q  <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      snap_bcd_q     <= snap_bcd_d;
      snap_dp_q      <= snap_dp_d;
      load_pending_q <= load_pending_d;
      en_prev_q      <= en_prev_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      an_q           <= an_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
module tb_bcd_seg_scan;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic [15:0] bcd;
  logic [3:0]  dp_in;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  an_a, an_b;
  logic        fs_a, fs_b;

  int checks   = 0;
  int failures = 0;

  // Active-high outputs
  bcd_seg_scan #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .bcd(bcd), .dp_in(dp_in),
    .seg(seg_a), .dp(dp_a), .an(an_a), .frame_start(fs_a)
  );

  // Active-low outputs, same stimulus
  bcd_seg_scan #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LZ(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .bcd(bcd), .dp_in(dp_in),
    .seg(seg_b), .dp(dp_b), .an(an_b), .frame_start(fs_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles, then present inputs with en=1; the next step() is edge k=0.
  task automatic restart(input logic [15:0] b, input logic [3:0] d);
    rst = 1'b1;
    en  = 1'b0;
    step();
    step();
    bcd   = b;
    dp_in = d;
    rst   = 1'b0;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    en    = 1'b1;
    bcd   = 16'h1234;
    dp_in = 4'b1111;
    step();
    step();
    checks++;
    if ({an_a, seg_a, dp_a, fs_a} !== {4'b0000, 7'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_a: an=%b seg=%h dp=%b fs=%b, want an=0000 seg=00 dp=0 fs=0", an_a, seg_a, dp_a, fs_a);
    end
    checks++;
    if ({an_b, seg_b, dp_b, fs_b} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_b: an=%b seg=%h dp=%b fs=%b, want an=1111 seg=7f dp=1 fs=0", an_b, seg_b, dp_b, fs_b);
    end
  endtask

  // One full frame from reset release; per-slot expectations given by caller.
  task automatic test_frame(input string name, input logic [15:0] b, input logic [3:0] d,
                            input logic [3:0][3:0] ean, input logic [3:0][6:0] eseg,
                            input logic [3:0] edp);
    logic [3:0] xan;
    logic [6:0] xseg;
    logic       xdp;
    logic       xfs;
    restart(b, d);
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 0 || (k % 4) == 3) begin
        xan = 4'b0000; xseg = 7'h00; xdp = 1'b0;
      end else begin
        xan = ean[k/4]; xseg = eseg[k/4]; xdp = edp[k/4];
      end
      xfs = (k == 0) || (k == 15);
      checks++;
      if ({an_a, seg_a, dp_a, fs_a} !== {xan, xseg, xdp, xfs}) begin
        failures++;
        $display("FAIL %s k=%0d: an=%b seg=%h dp=%b fs=%b, want an=%b seg=%h dp=%b fs=%b",
                 name, k, an_a, seg_a, dp_a, fs_a, xan, xseg, xdp, xfs);
      end
    end
  endtask

  // Input change mid-frame must not show until the next snapshot.
  task automatic test_snapshot();
    logic [3:0][6:0] f1 = {7'h06, 7'h5B, 7'h4F, 7'h66};
    logic [3:0] xan;
    logic [6:0] xseg;
    logic       xfs;
    restart(16'h1234, 4'b0000);
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 0 || (k % 4) == 3) begin
        xan = 4'b0000; xseg = 7'h00;
      end else if (k < 16) begin
        xan = 4'b0001 << (k/4); xseg = f1[k/4];
      end else begin
        xan = 4'b0001; xseg = 7'h7F;
      end
      xfs = (k == 0) || (k == 15);
      checks++;
      if ({an_a, seg_a, fs_a} !== {xan, xseg, xfs}) begin
        failures++;
        $display("FAIL snapshot k=%0d: an=%b seg=%h fs=%b, want an=%b seg=%h fs=%b",
                 k, an_a, seg_a, fs_a, xan, xseg, xfs);
      end
      if (k == 4) bcd = 16'h5678;
    end
  endtask

  // en drop mid-slot 2: dark and frozen, then gap, then the rest of slot 2.
  task automatic test_enable();
    logic [3:0] ran [4] = '{4'b0000, 4'b0100, 4'b0000, 4'b1000};
    logic [6:0] rseg[4] = '{7'h00, 7'h5B, 7'h00, 7'h06};
    restart(16'h1234, 4'b0000);
    for (int k = 0; k < 9; k++) step();
    checks++;
    if ({an_a, seg_a} !== {4'b0100, 7'h5B}) begin
      failures++;
      $display("FAIL enable_pre: an=%b seg=%h, want an=0100 seg=5b", an_a, seg_a);
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({an_a, seg_a, dp_a, fs_a} !== {4'b0000, 7'h00, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL enable_off k=%0d: an=%b seg=%h dp=%b fs=%b, want all 0", k, an_a, seg_a, dp_a, fs_a);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if ({an_a, seg_a, fs_a} !== {ran[k], rseg[k], 1'b0}) begin
        failures++;
        $display("FAIL enable_resume k=%0d: an=%b seg=%h fs=%b, want an=%b seg=%h fs=0",
                 k, an_a, seg_a, fs_a, ran[k], rseg[k]);
      end
    end
  endtask

  // rst during slot 2 aborts the frame; both polarities checked afterwards.
  task automatic test_reset_mid();
    logic lit;
    logic xfs;
    restart(16'h1234, 4'b0000);
    for (int k = 0; k < 10; k++) step();
    rst = 1'b1;
    bcd = 16'h0009;
    step();
    checks++;
    if ({an_a, seg_a, fs_a, an_b, seg_b} !== {4'b0000, 7'h00, 1'b0, 4'b1111, 7'h7F}) begin
      failures++;
      $display("FAIL reset_mid: an_a=%b seg_a=%h fs=%b an_b=%b seg_b=%h, want 0000 00 0 1111 7f",
               an_a, seg_a, fs_a, an_b, seg_b);
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      lit = (k != 0) && (k < 4) && (k % 4 != 3);
      xfs = (k == 0) || (k == 15);
      checks++;
      if ({an_a, seg_a, dp_a, fs_a} !== (lit ? {4'b0001, 7'h6F, 1'b0, xfs} : {4'b0000, 7'h00, 1'b0, xfs})) begin
        failures++;
        $display("FAIL reset_rel_a k=%0d: an=%b seg=%h dp=%b fs=%b, lit=%b", k, an_a, seg_a, dp_a, fs_a, lit);
      end
      checks++;
      if ({an_b, seg_b, dp_b, fs_b} !== (lit ? {4'b1110, 7'h10, 1'b1, xfs} : {4'b1111, 7'h7F, 1'b1, xfs})) begin
        failures++;
        $display("FAIL reset_rel_b k=%0d: an=%b seg=%h dp=%b fs=%b, lit=%b", k, an_b, seg_b, dp_b, fs_b, lit);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    bcd   = 16'h0000;
    dp_in = 4'b0000;
    test_reset();
    test_frame("basic", 16'h0123, 4'b0000,
               {4'b0000, 4'b0100, 4'b0010, 4'b0001}, {7'h00, 7'h06, 7'h5B, 7'h4F}, 4'b0000);
    test_frame("zero_dp", 16'h0000, 4'b1001,
               {4'b0000, 4'b0000, 4'b0000, 4'b0001}, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0001);
    test_frame("invalid", 16'h0A05, 4'b0000,
               {4'b0000, 4'b0100, 4'b0010, 4'b0001}, {7'h00, 7'h40, 7'h3F, 7'h6D}, 4'b0000);
    test_snapshot();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
